reflet_spi_master: RTL and testbench

- Byte-wide memory-mapped SPI controller; a responder on the CPU system bus, in the 0xFF00–0xFFFF peripheral window.
- The CPU initiates register reads and writes; this block answers them and runs an SPI mode-0 master (CPOL=0, CPHA=0) toward an external device.
- The completion interrupt is fed into one of the CPU ext_int lines.
- Read data is ORed onto the shared data return, so data_out is zero whenever the block is not addressed.

---
 rtl/reflet_spi_master_if.sv | 14 +
 rtl/reflet_spi_master.sv | 163 ++++++++++++++++
 tb/tb_reflet_spi_master.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reflet_spi_master_if.sv
// CPU-side register bus for the SPI controller: byte address/data with write strobe.
// The responder ORs data_out onto a shared return, so it drives zero when unselected.
interface reflet_spi_master_if #(
  parameter int base_addr_size = 15
);
  logic                      enable;
  logic [base_addr_size-1:0] addr;
  logic [7:0]                data_in;
  logic [7:0]                data_out;
  logic                      write_en;

  modport master (output enable, addr, data_in, write_en, input data_out);
  modport slave  (input enable, addr, data_in, write_en, output data_out);
endinterface

// File: rtl/reflet_spi_master.sv
// Memory-mapped SPI mode-0 master: CTRL/CLKDIV/DATA/SS registers,
// one byte per transfer, completion flag with optional interrupt.
module reflet_spi_master #(
  parameter int                        base_addr_size = 15,
  parameter logic [base_addr_size-1:0] base_addr      = 15'h7F40
) (
  input  logic                clk,
  input  logic                reset,
  reflet_spi_master_if.slave  bus,
  output logic                interrupt,
  output logic                sclk,
  output logic                mosi,
  input  logic                miso,
  output logic                ss_n
);
  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI} state_e;

  state_e      state_q, state_d;
  logic        irq_en_q, irq_en_d, lsb_first_q, lsb_first_d;
  logic        done_q, done_d, overflow_q, overflow_d;
  logic [7:0]  clkdiv_q, clkdiv_d, rx_reg_q, rx_reg_d;
  logic        ss_q, ss_d;
  logic [7:0]  tx_q, tx_d, rx_sh_q, rx_sh_d;
  logic [7:0]  div_q, div_d, phase_q, phase_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d, nxt_bit;
  logic        lsb_act_q, lsb_act_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic        sel, wr, busy, phase_end;
  logic [1:0]  off;

  always_comb begin
    sel  = bus.enable && (bus.addr[base_addr_size-1:2] == base_addr[base_addr_size-1:2]);
    off  = bus.addr[1:0];
    wr   = sel && bus.write_en;
    busy = (state_q != IDLE);
    bus.data_out = '0;
    if (sel) begin
      case (off)
        2'd0:    bus.data_out = {3'b000, overflow_q, done_q, busy, lsb_first_q, irq_en_q};
        2'd1:    bus.data_out = clkdiv_q;
        2'd2:    bus.data_out = rx_reg_q;
        default: bus.data_out = {7'b0, ss_q};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      irq_en_q   <= 1'b0;
      lsb_first_q <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      clkdiv_q   <= 8'hFF;
      rx_reg_q   <= '0;
      ss_q       <= 1'b0;
      tx_q       <= '0;
      rx_sh_q    <= '0;
      div_q      <= '0;
      phase_q    <= '0;
      bit_cnt_q  <= '0;
      lsb_act_q  <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      irq_en_q   <= irq_en_d;
      lsb_first_q <= lsb_first_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      clkdiv_q   <= clkdiv_d;
      rx_reg_q   <= rx_reg_d;
      ss_q       <= ss_d;
      tx_q       <= tx_d;
      rx_sh_q    <= rx_sh_d;
      div_q      <= div_d;
      phase_q    <= phase_d;
      bit_cnt_q  <= bit_cnt_d;
      lsb_act_q  <= lsb_act_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    irq_en_d    = irq_en_q;
    lsb_first_d = lsb_first_q;
    done_d      = done_q;
    overflow_d  = overflow_q;
    clkdiv_d    = clkdiv_q;
    rx_reg_d    = rx_reg_q;
    ss_d        = ss_q;
    tx_d        = tx_q;
    rx_sh_d     = rx_sh_q;
    div_d       = div_q;
    phase_d     = phase_q;
    bit_cnt_d   = bit_cnt_q;
    lsb_act_d   = lsb_act_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    phase_end   = (phase_q == div_q);
    nxt_bit     = bit_cnt_q + 3'd1;

    // Register writes come first so that the flag sets below win same-edge clears.
    if (wr && off == 2'd0) begin
      irq_en_d    = bus.data_in[0];
      lsb_first_d = bus.data_in[1];
      if (bus.data_in[3]) done_d = 1'b0;
      if (bus.data_in[4]) overflow_d = 1'b0;
    end
    if (wr && off == 2'd1) clkdiv_d = bus.data_in;
    if (wr && off == 2'd3) ss_d = bus.data_in[0];
    if (wr && off == 2'd2 && busy) overflow_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (wr && off == 2'd2) begin
          state_d   = SHIFT_LO;
          tx_d      = bus.data_in;
          div_d     = clkdiv_q;
          lsb_act_d = lsb_first_q;
          bit_cnt_d = '0;
          phase_d   = '0;
          mosi_d    = lsb_first_q ? bus.data_in[0] : bus.data_in[7];
        end
      end
      SHIFT_LO: begin
        if (phase_end) begin
          phase_d = '0;
          sclk_d  = 1'b1;
          rx_sh_d = lsb_act_q ? {miso, rx_sh_q[7:1]} : {rx_sh_q[6:0], miso};
          state_d = SHIFT_HI;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      SHIFT_HI: begin
        if (phase_end) begin
          phase_d = '0;
          sclk_d  = 1'b0;
          if (bit_cnt_q == 3'd7) begin
            state_d  = IDLE;
            done_d   = 1'b1;
            rx_reg_d = rx_sh_q;
            mosi_d   = 1'b0;
          end else begin
            bit_cnt_d = nxt_bit;
            mosi_d    = lsb_act_q ? tx_q[nxt_bit] : tx_q[~nxt_bit];
            state_d   = SHIFT_LO;
          end
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign interrupt = done_q && irq_en_q;
  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
  assign ss_n      = ~ss_q;
endmodule

// File: tb/tb_reflet_spi_master.sv
// Self-checking bench for reflet_spi_master: register access, loopback and
// device-driven transfers, flag collisions, reset and address decode.
module tb_reflet_spi_master;
  localparam int          AW   = 15;
  localparam logic [14:0] BASE = 15'h7F40;

  logic clk = 1'b0;
  logic reset;
  logic interrupt, sclk, mosi, miso, ss_n;
  int   errors = 0;
  int   checks = 0;

  logic       loop_mode = 1'b0;
  logic [7:0] dev_byte  = 8'h00;
  logic       dev_lsb   = 1'b0;
  int         rise_cnt  = 0;
  int         rise_base = 0;
  int         dev_idx;

  reflet_spi_master_if #(.base_addr_size(AW)) bus ();

  reflet_spi_master #(.base_addr_size(AW), .base_addr(BASE)) dut (
    .clk(clk), .reset(reset), .bus(bus), .interrupt(interrupt),
    .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n)
  );

  always #5 clk = ~clk;

  // External device: shifts dev_byte out, advancing after each rising sclk.
  always @(posedge sclk) rise_cnt = rise_cnt + 1;
  always_comb begin
    dev_idx = rise_cnt - rise_base;
    if (loop_mode)                    miso = mosi;
    else if (dev_idx < 0 || dev_idx > 7) miso = 1'b0;
    else if (dev_lsb)                 miso = dev_byte[dev_idx];
    else                              miso = dev_byte[7 - dev_idx];
  end

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int unsigned i = 0; i < 8; i++) r[i] = v[7 - i];
    return r;
  endfunction

  // Serial order as seen on the wire, first bit in the MSB position.
  function automatic logic [7:0] wire_order(input logic [7:0] tx, input logic lsb);
    return lsb ? rev8(tx) : tx;
  endfunction

  task automatic idle_bus();
    bus.enable = 1'b0; bus.addr = '0; bus.data_in = '0; bus.write_en = 1'b0;
  endtask

  task automatic wr(input logic [1:0] off, input logic [7:0] d);
    bus.enable = 1'b1; bus.addr = BASE | {13'b0, off}; bus.data_in = d; bus.write_en = 1'b1;
    @(posedge clk); #1;
    bus.write_en = 1'b0; bus.enable = 1'b0;
  endtask

  task automatic rd(input logic [1:0] off, output logic [7:0] d);
    bus.enable = 1'b1; bus.addr = BASE | {13'b0, off}; bus.write_en = 1'b0;
    #1 d = bus.data_out;
    bus.enable = 1'b0;
  endtask

  // Starts a DATA write, then samples once per cycle until busy drops.
  // Optionally injects one register write landing on edge inj_cycle+1.
  task automatic do_transfer(input logic [7:0] tx, input int inj_cycle,
                             input logic [1:0] inj_off, input logic [7:0] inj_data,
                             output int cycles, output logic [7:0] seq, output int rises,
                             output int min_run, output int max_run);
    logic b, s, prev_s;
    int run;
    rise_base = rise_cnt;
    bus.enable = 1'b1; bus.addr = BASE | 15'd2; bus.data_in = tx; bus.write_en = 1'b1;
    @(posedge clk);
    cycles = -1; seq = '0; rises = 0; min_run = 100000; max_run = 0; prev_s = 1'b0; run = 0;
    for (int k = 0; k < 5000; k++) begin
      if (k > 0) @(posedge clk);
      #1;
      bus.enable = 1'b1; bus.addr = BASE; bus.write_en = 1'b0;
      #1;
      b = bus.data_out[2];
      s = sclk;
      if (!b) begin
        cycles = k;
        if (run > 0) begin
          if (run < min_run) min_run = run;
          if (run > max_run) max_run = run;
        end
        break;
      end
      if (k > 0 && s && !prev_s) begin
        rises++;
        seq = {seq[6:0], mosi};
      end
      if (k == 0 || s == prev_s) run++;
      else begin
        if (run < min_run) min_run = run;
        if (run > max_run) max_run = run;
        run = 1;
      end
      prev_s = s;
      if (k == inj_cycle) begin
        bus.addr = BASE | {13'b0, inj_off}; bus.data_in = inj_data; bus.write_en = 1'b1;
      end
    end
    bus.write_en = 1'b0; bus.enable = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] r;
    reset = 1'b1;
    idle_bus();
    repeat (3) @(posedge clk);
    #1;
    rd(2'd0, r); checks++; if (r !== 8'h00) begin errors++; $display("FAIL reset_ctrl got=%h exp=00", r); end
    rd(2'd1, r); checks++; if (r !== 8'hFF) begin errors++; $display("FAIL reset_clkdiv got=%h exp=FF", r); end
    rd(2'd2, r); checks++; if (r !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", r); end
    rd(2'd3, r); checks++; if (r !== 8'h00) begin errors++; $display("FAIL reset_ss got=%h exp=00", r); end
    checks++; if ({ss_n, sclk, mosi, interrupt} !== 4'b1000) begin
      errors++; $display("FAIL reset_pins got ss_n/sclk/mosi/irq=%b exp=1000", {ss_n, sclk, mosi, interrupt});
    end
    bus.enable = 1'b0; bus.addr = BASE | 15'd1; #1;
    checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL reset_unsel got=%h exp=00", bus.data_out); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_loopback_msb();
    int cyc, rises, mn, mx; logic [7:0] seq, r;
    wr(2'd1, 8'h00);
    wr(2'd3, 8'h01);
    checks++; if (ss_n !== 1'b0) begin errors++; $display("FAIL ss_assert got=%b exp=0", ss_n); end
    loop_mode = 1'b1;
    do_transfer(8'hA5, -1, 2'd0, 8'h00, cyc, seq, rises, mn, mx);
    checks++; if (cyc !== 16) begin errors++; $display("FAIL msb_cycles got=%0d exp=16", cyc); end
    checks++; if (rises !== 8) begin errors++; $display("FAIL msb_rises got=%0d exp=8", rises); end
    checks++; if (seq !== 8'hA5) begin errors++; $display("FAIL msb_mosi got=%h exp=A5", seq); end
    rd(2'd0, r); checks++; if (r !== 8'h08) begin errors++; $display("FAIL msb_ctrl got=%h exp=08", r); end
    rd(2'd2, r); checks++; if (r !== 8'hA5) begin errors++; $display("FAIL msb_data got=%h exp=A5", r); end
    checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL msb_mosi_idle got=%b exp=0", mosi); end
  endtask

  task automatic test_lsb_div();
    int cyc, rises, mn, mx; logic [7:0] seq, r, tx;
    loop_mode = 1'b0; dev_byte = 8'h3C; dev_lsb = 1'b1;
    wr(2'd0, 8'h02);
    wr(2'd1, 8'h03);
    tx = 8'($urandom);
    do_transfer(tx, -1, 2'd0, 8'h00, cyc, seq, rises, mn, mx);
    checks++; if (cyc !== 64) begin errors++; $display("FAIL lsb_cycles got=%0d exp=64", cyc); end
    checks++; if (mn !== 4 || mx !== 4) begin errors++; $display("FAIL lsb_phase got=%0d..%0d exp=4..4", mn, mx); end
    checks++; if (seq !== wire_order(tx, 1'b1)) begin
      errors++; $display("FAIL lsb_mosi got=%h exp=%h", seq, wire_order(tx, 1'b1));
    end
    rd(2'd2, r); checks++; if (r !== 8'h3C) begin errors++; $display("FAIL lsb_data got=%h exp=3C", r); end
    rd(2'd0, r); checks++; if (r !== 8'h0A) begin errors++; $display("FAIL lsb_ctrl got=%h exp=0A", r); end
  endtask

  task automatic test_irq_overflow();
    int cyc, rises, mn, mx; logic [7:0] seq, r, tx;
    wr(2'd0, 8'h09);
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL irq_idle got=%b exp=0", interrupt); end
    wr(2'd1, 8'h00);
    loop_mode = 1'b1;
    tx = 8'($urandom);
    do_transfer(tx, 5, 2'd2, ~tx, cyc, seq, rises, mn, mx);
    checks++; if (cyc !== 16) begin errors++; $display("FAIL ovf_cycles got=%0d exp=16", cyc); end
    checks++; if (seq !== tx) begin errors++; $display("FAIL ovf_mosi got=%h exp=%h", seq, tx); end
    rd(2'd2, r); checks++; if (r !== tx) begin errors++; $display("FAIL ovf_data got=%h exp=%h", r, tx); end
    rd(2'd0, r); checks++; if (r !== 8'h19) begin errors++; $display("FAIL ovf_ctrl got=%h exp=19", r); end
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL irq_set got=%b exp=1", interrupt); end
    wr(2'd0, 8'h09);
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL irq_clear got=%b exp=0", interrupt); end
    rd(2'd0, r); checks++; if (r !== 8'h11) begin errors++; $display("FAIL ovf_hold got=%h exp=11", r); end
    wr(2'd0, 8'h11);
    rd(2'd0, r); checks++; if (r !== 8'h01) begin errors++; $display("FAIL ovf_clear got=%h exp=01", r); end
  endtask

  task automatic test_collisions();
    int cyc, rises, mn, mx; logic [7:0] seq, r;
    wr(2'd0, 8'h00);
    loop_mode = 1'b1;
    do_transfer(8'h5C, 15, 2'd0, 8'h08, cyc, seq, rises, mn, mx);
    rd(2'd0, r); checks++; if (r !== 8'h08) begin errors++; $display("FAIL done_set_wins got=%h exp=08", r); end
    wr(2'd0, 8'h08);
    do_transfer(8'hC3, 15, 2'd2, 8'h5A, cyc, seq, rises, mn, mx);
    checks++; if (cyc !== 16) begin errors++; $display("FAIL cmpl_write_cycles got=%0d exp=16", cyc); end
    rd(2'd0, r); checks++; if (r !== 8'h18) begin errors++; $display("FAIL cmpl_write_ctrl got=%h exp=18", r); end
    rd(2'd2, r); checks++; if (r !== 8'hC3) begin errors++; $display("FAIL cmpl_write_data got=%h exp=C3", r); end
    wr(2'd0, 8'h18);
    wr(2'd1, 8'h01);
    do_transfer(8'h96, 5, 2'd1, 8'h00, cyc, seq, rises, mn, mx);
    checks++; if (cyc !== 32 || mn !== 2 || mx !== 2) begin
      errors++; $display("FAIL div_latched got cycles=%0d phase=%0d..%0d exp 32 2..2", cyc, mn, mx);
    end
    do_transfer(8'h69, -1, 2'd0, 8'h00, cyc, seq, rises, mn, mx);
    checks++; if (cyc !== 16) begin errors++; $display("FAIL div_next got=%0d exp=16", cyc); end
  endtask

  task automatic test_random();
    int cyc, rises, mn, mx, div; logic [7:0] seq, r, tx; logic lsb;
    loop_mode = 1'b0;
    for (int n = 0; n < 6; n++) begin
      div = int'($urandom_range(0, 2));
      lsb = 1'($urandom);
      tx = 8'($urandom);
      dev_byte = 8'($urandom);
      dev_lsb = lsb;
      wr(2'd0, {6'b0, lsb, 1'b0});
      wr(2'd1, 8'(div));
      do_transfer(tx, -1, 2'd0, 8'h00, cyc, seq, rises, mn, mx);
      checks++; if (cyc !== 16 * (div + 1)) begin errors++; $display("FAIL rnd_cycles[%0d] got=%0d exp=%0d", n, cyc, 16 * (div + 1)); end
      checks++; if (seq !== wire_order(tx, lsb)) begin errors++; $display("FAIL rnd_mosi[%0d] got=%h exp=%h", n, seq, wire_order(tx, lsb)); end
      rd(2'd2, r); checks++; if (r !== dev_byte) begin errors++; $display("FAIL rnd_rx[%0d] got=%h exp=%h", n, r, dev_byte); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] r;
    wr(2'd1, 8'h03);
    bus.enable = 1'b1; bus.addr = BASE | 15'd2; bus.data_in = 8'hE7; bus.write_en = 1'b1;
    @(posedge clk); #1;
    idle_bus();
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    rd(2'd0, r); checks++; if (r !== 8'h00) begin errors++; $display("FAIL rst_mid_ctrl got=%h exp=00", r); end
    checks++; if ({sclk, ss_n} !== 2'b01) begin errors++; $display("FAIL rst_mid_pins got sclk/ss_n=%b exp=01", {sclk, ss_n}); end
    rd(2'd2, r); checks++; if (r !== 8'h00) begin errors++; $display("FAIL rst_mid_data got=%h exp=00", r); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_decode();
    logic [7:0] r;
    wr(2'd1, 8'h42);
    bus.enable = 1'b1; bus.addr = BASE + 15'd5; bus.data_in = 8'h99; bus.write_en = 1'b1;
    @(posedge clk); #1;
    bus.addr = BASE + 15'd7; bus.data_in = 8'h01;
    @(posedge clk); #1;
    bus.enable = 1'b0; bus.addr = BASE | 15'd1; bus.data_in = 8'h77;
    @(posedge clk); #1;
    idle_bus();
    rd(2'd1, r); checks++; if (r !== 8'h42) begin errors++; $display("FAIL decode_clkdiv got=%h exp=42", r); end
    checks++; if (ss_n !== 1'b1) begin errors++; $display("FAIL decode_ss got=%b exp=1", ss_n); end
    bus.enable = 1'b1; bus.addr = BASE + 15'd5; #1;
    checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL decode_other got=%h exp=00", bus.data_out); end
    bus.enable = 1'b0; bus.addr = BASE | 15'd1; #1;
    checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL decode_disabled got=%h exp=00", bus.data_out); end
    idle_bus();
  endtask

  initial begin
    reset = 1'b1;
    idle_bus();
    test_reset();
    test_loopback_msb();
    test_lsb_div();
    test_irq_overflow();
    test_collisions();
    test_random();
    test_reset_mid();
    test_decode();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
